johnson_counter: RTL and testbench
==================================

# johnson_counter

Free-running twisted-ring (Johnson) counter. Every rising clock edge it shifts its register one place toward the LSB and feeds the complement of the old LSB into the MSB. A WIDTH-bit instance walks through 2×WIDTH distinct codes, and exactly one bit changes between adjacent codes. It is a leaf sequencer, used wherever a glitch-free, easily decoded phase or state sequence is needed.

## Interface
Parameters:
- WIDTH, default 4: counter width in bits; legal values are 2 or more.

Ports:
- clk, input, 1: the block's single clock; all state updates on its rising edge.
- reset, input, 1: asynchronous, active-high reset; forces count to all zeros immediately.
- count, output, WIDTH: the counter state, driven directly from the register with no output decode.

Clocking and reset are fixed for this block: one clock, and reset is asynchronous and active-high.

## Operation
- State is a WIDTH-bit register, and count is that register.
- Next state:
  - count[WIDTH-1] <= ~count[0]
  - count[i] <= count[i+1] for i = WIDTH-2 down to 0
- There is no enable input; the counter advances on every clk rising edge while reset is low.
- Legal sequence for WIDTH=4, starting from reset: 0000 → 1000 → 1100 → 1110 → 1111 → 0111 → 0011 → 0001 → 0000, repeating.
- Legal codes are exactly the 2×WIDTH values of the form "ones-run at the MSB end, then zeros" or "zeros-run at the MSB end, then ones".
- Every other value is an illegal code, reachable only through an upset or a forced state.
- There is no arithmetic, and therefore no overflow; wrap-around from 0001 to 0000 is part of the normal sequence.

## Timing
- Reset value: count = all zeros.
  - Applied asynchronously; it does not wait for a clock edge.
  - It is held for as long as reset is high.
- Reset mid-sequence: count goes to 0 immediately, whatever its current state; the sequence restarts from 0000.
- Release of reset: the first clk rising edge after reset deasserts produces 1000.
- Latency: count updates one clk edge after the state it is derived from; there is no combinational path from any input to count.
- Reset asserted together with a clk edge: reset wins, and count stays at 0.
- Period: 2×WIDTH clock edges (8 for the default WIDTH).
- Clock duty cycle: arbitrary; only rising edges are significant.

## Configuration
- Macro: JOHNSON_COUNTER_SELF_CORRECT_EN.
- With the macro defined:
  - Any illegal code present in the register is replaced by all zeros on the next clk rising edge.
  - The legal sequence then resumes: the following edge produces 1000.
  - Legal codes advance exactly as described in Operation.
- Without the macro:
  - Pure shift logic; illegal codes are not detected.
  - Illegal codes circulate in a parasitic cycle. For WIDTH=4 this is 0100 → 1010 → 1101 → 0110 → 1011 → 0101 → 0010 → 1001 → 0100.
- Behaviour from legal states is identical in both builds.

## Test plan
- Async reset: start with clk low; pulse reset high for 5 ns with no clk edge → count = 0000 during the pulse, with no edge needed.
- Full cycle: after reset, apply 8 clk pulses → count reads 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000, in that order.
- Wrap and continue: apply a 9th pulse → 1000; across 16 pulses each code appears exactly twice, and every step changes exactly one bit.
- Reset mid-sequence: at count = 1110, assert reset between edges → count = 0000 immediately; the first edge after release gives 1000.
- Illegal state with JOHNSON_COUNTER_SELF_CORRECT_EN defined: force the register to 0100 → next edge gives 0000, the edge after gives 1000.
- Illegal state with the macro undefined: force 0100 → the next two edges give 1010, then 1101; count never reaches 0000 without reset.

Source files
------------

// File: rtl/johnson_counter.sv
// Free-running WIDTH-bit twisted-ring (Johnson) counter, asynchronous active-high reset.
// Define JOHNSON_COUNTER_SELF_CORRECT_EN to force illegal codes back to zero on the next edge.
module johnson_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] shift_next;

    assign shift_next = {~count_q[0], count_q[WIDTH-1:1]};

`ifdef JOHNSON_COUNTER_SELF_CORRECT_EN
    logic [WIDTH-2:0] bit_diff;
    logic             code_legal;

    // A legal code has at most one boundary between adjacent bits.
    assign bit_diff   = count_q[WIDTH-1:1] ^ count_q[WIDTH-2:0];
    assign code_legal = ((bit_diff & (bit_diff - 1'b1)) == '0);

    always_comb begin
        count_d = shift_next;
        if (!code_legal) begin
            count_d = '0;
        end
    end
`else
    always_comb begin
        count_d = shift_next;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_johnson_counter.sv
// Directed self-checking bench for johnson_counter (WIDTH=4), covering both
// builds of JOHNSON_COUNTER_SELF_CORRECT_EN.
module tb_johnson_counter;

    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] count;

    int n_checks;
    int n_fail;

    logic [WIDTH-1:0] legal_seq [8];
    logic [WIDTH-1:0] parasitic_seq [8];
    int               tally [16];

    johnson_counter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .count (count)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", tag, observed, expected);
        end
    endtask

    // One full clock period; returns with clk low, mid-way between edges.
    task automatic pulse();
        clk = 1'b1;
        #5;
        clk = 1'b0;
        #5;
    endtask

    initial begin
        logic [WIDTH-1:0] prev;
        logic [WIDTH-1:0] tmp;

        n_checks = 0;
        n_fail   = 0;
        legal_seq[0] = 4'b1000; legal_seq[1] = 4'b1100;
        legal_seq[2] = 4'b1110; legal_seq[3] = 4'b1111;
        legal_seq[4] = 4'b0111; legal_seq[5] = 4'b0011;
        legal_seq[6] = 4'b0001; legal_seq[7] = 4'b0000;
        parasitic_seq[0] = 4'b1010; parasitic_seq[1] = 4'b1101;
        parasitic_seq[2] = 4'b0110; parasitic_seq[3] = 4'b1011;
        parasitic_seq[4] = 4'b0101; parasitic_seq[5] = 4'b0010;
        parasitic_seq[6] = 4'b1001; parasitic_seq[7] = 4'b0100;
        for (int i = 0; i < 16; i++) tally[i] = 0;

        clk   = 1'b0;
        reset = 1'b0;
        #3;

        // Asynchronous reset with no clock edge.
        reset = 1'b1;
        #1;
        check("async_rst_immediate", 32'(count), 32'(4'b0000));
        #4;
        check("async_rst_held", 32'(count), 32'(4'b0000));
        reset = 1'b0;
        #5;
        check("rst_release_no_edge", 32'(count), 32'(4'b0000));

        // First full cycle.
        for (int i = 0; i < 8; i++) begin
            pulse();
            check($sformatf("cycle1_step%0d", i), 32'(count), 32'(legal_seq[i]));
        end

        // Sixteen more edges: wrap, code tally and single-bit steps.
        prev = count;
        for (int i = 0; i < 16; i++) begin
            pulse();
            tmp = count;
            tally[tmp]++;
            check($sformatf("wrap_step%0d", i), 32'(count), 32'(legal_seq[i % 8]));
            check($sformatf("one_bit_step%0d", i), 32'($countones(tmp ^ prev)), 32'd1);
            prev = tmp;
        end
        for (int i = 0; i < 8; i++) begin
            tmp = legal_seq[i];
            check($sformatf("tally_%b", tmp), 32'(tally[tmp]), 32'd2);
        end

        // Reset mid-sequence at 1110.
        pulse(); pulse(); pulse();
        check("pre_midrst", 32'(count), 32'(4'b1110));
        #2;
        reset = 1'b1;
        #1;
        check("midrst_immediate", 32'(count), 32'(4'b0000));
        #2;
        reset = 1'b0;
        #2;
        pulse();
        check("midrst_first_edge", 32'(count), 32'(4'b1000));

        // Reset arriving together with a clock edge.
        pulse();
        check("pre_coincident", 32'(count), 32'(4'b1100));
        reset = 1'b1;
        clk   = 1'b1;
        #1;
        check("coincident_rst", 32'(count), 32'(4'b0000));
        #4;
        clk = 1'b0;
        #3;
        reset = 1'b0;
        #2;
        pulse();
        check("coincident_release", 32'(count), 32'(4'b1000));

        // Illegal code forced into the register.
        force dut.count_q = 4'b0100;
        #1;
        release dut.count_q;
        #1;
        check("forced_illegal", 32'(count), 32'(4'b0100));
`ifdef JOHNSON_COUNTER_SELF_CORRECT_EN
        pulse();
        check("selfcorrect_zero", 32'(count), 32'(4'b0000));
        pulse();
        check("selfcorrect_resume", 32'(count), 32'(4'b1000));
        pulse();
        check("selfcorrect_next", 32'(count), 32'(4'b1100));
`else
        for (int i = 0; i < 8; i++) begin
            pulse();
            check($sformatf("parasitic_step%0d", i), 32'(count), 32'(parasitic_seq[i]));
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
